// File: rtl/spawn_scheduler_if.sv
// Spawn request channel from the scheduler to the obstacle manager.
// The scheduler holds valid, lane and kind stable until ready is seen.
interface spawn_scheduler_if;
    logic       spawn_valid_out;
    logic       spawn_ready_in;
    logic [1:0] spawn_lane_out;
    logic       spawn_kind_out;

    modport master (
        output spawn_valid_out,
        output spawn_lane_out,
        output spawn_kind_out,
        input  spawn_ready_in
    );

    modport slave (
        input  spawn_valid_out,
        input  spawn_lane_out,
        input  spawn_kind_out,
        output spawn_ready_in
    );
endinterface

// File: rtl/spawn_scheduler.sv
// Obstacle spawn scheduler: arms the 100 ms game timer with a jittered interval
// and issues a spawn request on each expiry, shrinking intervals as the level ramps.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | game stopped; ramp counter and level held at zero
// ARM   | one cycle: pulse timer start and load the computed interval
// WAIT  | timer running; expiry latches lane/kind, enable drop aborts
// SPAWN | request valid on the spawn channel until accepted
module spawn_scheduler #(
    parameter logic [5:0]  MAX_BASE     = 6'd40,
    parameter logic [5:0]  MIN_INTERVAL = 6'd5,
    parameter logic [5:0]  STEP         = 6'd2,
    parameter logic [7:0]  RAMP_PULSES  = 8'd100,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic        JITTER_EN    = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       enable_in,
    input  logic                       timer_expired_in,
    input  logic                       pulse_100ms_in,
    output logic                       timer_start_out,
    output logic [5:0]                 timer_value_out,
    output logic [3:0]                 level_out,
    spawn_scheduler_if.master          spawn_bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] SPAWN = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  LEVEL_MAX = 4'd15;
    localparam logic [7:0]  RAMP_LAST = RAMP_PULSES - 8'd1;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [7:0]  ramp_cnt;
    logic [3:0]  level;
    logic [9:0]  step_total;
    logic [9:0]  base_raw;
    logic [5:0]  base;
    logic [3:0]  jitter;
    logic [5:0]  interval;
    logic [1:0]  lane_next;
    logic        accepted;

    // Galois right-shift form: feedback taps applied when the bit shifted out is 1.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // Base shrinks with level; a product larger than MAX_BASE would wrap, so it floors too.
    always_comb begin
        step_total = {6'd0, level} * {4'd0, STEP};
        base_raw   = {4'd0, MAX_BASE} - step_total;
        if ((step_total > {4'd0, MAX_BASE}) || (base_raw < {4'd0, MIN_INTERVAL})) begin
            base = MIN_INTERVAL;
        end else begin
            base = base_raw[5:0];
        end
    end

    always_comb begin
        jitter = JITTER_EN ? lfsr[3:0] : 4'd0;
        if ({1'b0, base} > ({3'd0, jitter} + {1'b0, MIN_INTERVAL})) begin
            interval = base - {2'd0, jitter};
        end else begin
            interval = MIN_INTERVAL;
        end
    end

    // Only three lanes exist; the fourth LFSR code folds onto the middle lane.
    always_comb begin
        lane_next = (lfsr[5:4] == 2'b11) ? 2'b01 : lfsr[5:4];
        accepted  = spawn_bus.spawn_valid_out && spawn_bus.spawn_ready_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lfsr <= LFSR_SEED;
        end else if (enable_in) begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ramp_cnt <= 8'd0;
            level    <= 4'd0;
        end else if (state == IDLE) begin
            ramp_cnt <= 8'd0;
            level    <= 4'd0;
        end else if (pulse_100ms_in) begin
            if (ramp_cnt == RAMP_LAST) begin
                ramp_cnt <= 8'd0;
                if (level != LEVEL_MAX) begin
                    level <= level + 4'd1;
                end
            end else begin
                ramp_cnt <= ramp_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                     <= IDLE;
            timer_start_out           <= 1'b0;
            timer_value_out           <= 6'd0;
            spawn_bus.spawn_valid_out <= 1'b0;
            spawn_bus.spawn_lane_out  <= 2'd0;
            spawn_bus.spawn_kind_out  <= 1'b0;
        end else begin
            timer_start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    timer_start_out <= 1'b1;
                    timer_value_out <= interval;
                    state           <= WAIT;
                end
                WAIT: begin
                    // Expiry outranks a simultaneous enable drop so no earned spawn is lost.
                    if (timer_expired_in) begin
                        spawn_bus.spawn_valid_out <= 1'b1;
                        spawn_bus.spawn_lane_out  <= lane_next;
                        spawn_bus.spawn_kind_out  <= lfsr[6];
                        state                     <= SPAWN;
                    end else if (!enable_in) begin
                        timer_value_out <= 6'd0;
                        state           <= IDLE;
                    end
                end
                SPAWN: begin
                    if (accepted) begin
                        spawn_bus.spawn_valid_out <= 1'b0;
                        state                     <= enable_in ? ARM : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign level_out = level;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: three instances in lockstep (no jitter, jitter, steep step)
// checked against an independent LFSR/interval model and a lane/kind scoreboard.
module tb_spawn_scheduler;

    logic clk_in = 1'b0;
    logic rst_n;
    logic enable;
    logic expired;
    logic pulse;
    logic ready;

    always #5 clk_in = ~clk_in;

    spawn_scheduler_if bus0 ();
    spawn_scheduler_if bus1 ();
    spawn_scheduler_if bus2 ();

    assign bus0.spawn_ready_in = ready;
    assign bus1.spawn_ready_in = ready;
    assign bus2.spawn_ready_in = ready;

    logic       start0, start1, start2;
    logic [5:0] val0, val1, val2;
    logic [3:0] lvl0, lvl1, lvl2;

    spawn_scheduler #(.JITTER_EN(1'b0)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n), .enable_in(enable),
        .timer_expired_in(expired), .pulse_100ms_in(pulse),
        .timer_start_out(start0), .timer_value_out(val0), .level_out(lvl0),
        .spawn_bus(bus0)
    );

    spawn_scheduler dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n), .enable_in(enable),
        .timer_expired_in(expired), .pulse_100ms_in(pulse),
        .timer_start_out(start1), .timer_value_out(val1), .level_out(lvl1),
        .spawn_bus(bus1)
    );

    spawn_scheduler #(.JITTER_EN(1'b0), .STEP(6'd3)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n), .enable_in(enable),
        .timer_expired_in(expired), .pulse_100ms_in(pulse),
        .timer_start_out(start2), .timer_value_out(val2), .level_out(lvl2),
        .spawn_bus(bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int exp_level = 0;
    logic        valid_q = 1'b0;
    logic [2:0]  exp_lk = 3'd0;
    logic [2:0]  sb_q[$];
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_hist;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [5:0] exp_interval(input int lvl, input logic [15:0] s,
                                                input bit jit, input int step);
        int base;
        int j;
        base = 40 - lvl * step;
        if (base < 5) base = 5;
        j = jit ? int'(s[3:0]) : 0;
        return (base > j + 5) ? 6'(base - j) : 6'd5;
    endfunction

    // Reference LFSR; lfsr_hist is the value the DUT saw at the most recent edge.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 16'hACE1;
            lfsr_hist <= 16'hACE1;
        end else begin
            lfsr_hist <= lfsr_m;
            if (enable) lfsr_m <= lfsr_step(lfsr_m);
        end
    end

    task automatic push_expected();
        logic [1:0] ln;
        ln = (lfsr_m[5:4] == 2'b11) ? 2'b01 : lfsr_m[5:4];
        sb_q.push_back({ln, lfsr_m[6]});
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
        if (start0) begin
            n_starts++;
            check_eq("value_nojit", val0, exp_interval(exp_level, lfsr_hist, 1'b0, 2));
            check_eq("value_jit",   val1, exp_interval(exp_level, lfsr_hist, 1'b1, 2));
            check_eq("value_step3", val2, exp_interval(exp_level, lfsr_hist, 1'b0, 3));
        end
        if (bus0.spawn_valid_out && !valid_q) begin
            check_eq("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) exp_lk = sb_q.pop_front();
        end
        if (bus0.spawn_valid_out) begin
            check_eq("lane_kind0", {bus0.spawn_lane_out, bus0.spawn_kind_out}, exp_lk);
            check_eq("lane_kind1", {bus1.spawn_lane_out, bus1.spawn_kind_out}, exp_lk);
            check_eq("lane_not3", bus0.spawn_lane_out == 2'b11, 0);
        end
        valid_q = bus0.spawn_valid_out;
    endtask

    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!start0 && n < max_cyc);
        check_eq("start_seen", start0, 1);
    endtask

    task automatic do_spawn(input int hold);
        push_expected();
        expired = 1'b1;
        cyc();
        expired = 1'b0;
        check_eq("expiry_to_valid", bus0.spawn_valid_out, 1);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check_eq("valid_held", bus0.spawn_valid_out, 1);
        end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        check_eq("valid_dropped", bus0.spawn_valid_out, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit %0d", 2000000);
        $fatal(1);
    end

    initial begin
        int n;
        int s;
        rst_n = 1'b0; enable = 1'b0; expired = 1'b0; pulse = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        check_eq("rst_start",  start0 | start1 | start2, 0);
        check_eq("rst_value",  val0 | val1 | val2, 0);
        check_eq("rst_valid",  bus0.spawn_valid_out | bus1.spawn_valid_out | bus2.spawn_valid_out, 0);
        check_eq("rst_level",  lvl0 | lvl1 | lvl2, 0);
        check_eq("rst_lane",   bus0.spawn_lane_out, 0);
        cyc();

        // enable rise -> start two cycles later, single pulse
        enable = 1'b1;
        wait_start(6, n);
        check_eq("enable_to_start", n, 2);
        check_eq("level_zero", lvl0, 0);
        cyc();
        check_eq("start_once", start0, 0);
        repeat (2) cyc();

        // stalled handshake, then restart latency
        do_spawn(5);
        wait_start(6, n);
        check_eq("accept_to_start", n + 1, 2);

        // ramp boundary: 99 pulses keep level 0, the 100th bumps it
        cyc();
        pulse = 1'b1;
        repeat (99) cyc();
        check_eq("level_at_99", lvl0, 0);
        cyc();
        pulse = 1'b0;
        check_eq("level_at_100", lvl0, 1);
        check_eq("level_at_100_s3", lvl2, 1);
        exp_level = 1;
        do_spawn(0);
        wait_start(6, n);

        pulse = 1'b1;
        repeat (1800) cyc();
        pulse = 1'b0;
        check_eq("level_saturated", lvl0, 15);
        check_eq("level_saturated_s3", lvl2, 15);
        exp_level = 15;
        do_spawn(1);
        wait_start(6, n);

        // enable drop in WAIT returns to IDLE and clears level/value
        cyc();
        enable = 1'b0;
        repeat (2) cyc();
        exp_level = 0;
        check_eq("abort_value", val0, 0);
        check_eq("abort_level", lvl0, 0);
        check_eq("abort_valid", bus0.spawn_valid_out, 0);
        s = n_starts;
        expired = 1'b1;
        cyc();
        expired = 1'b0;
        repeat (3) cyc();
        check_eq("idle_expiry_ignored", bus0.spawn_valid_out, 0);
        check_eq("idle_no_start", n_starts, s);

        // expiry during the ARM cycle is stale
        enable = 1'b1;
        cyc();
        expired = 1'b1;
        cyc();
        expired = 1'b0;
        check_eq("arm_start", start0, 1);
        repeat (3) cyc();
        check_eq("arm_expiry_ignored", bus0.spawn_valid_out, 0);

        // expiry coinciding with enable drop still spawns; then back to IDLE
        push_expected();
        expired = 1'b1;
        enable  = 1'b0;
        cyc();
        expired = 1'b0;
        check_eq("expiry_wins", bus0.spawn_valid_out, 1);
        repeat (3) begin
            cyc();
            check_eq("valid_held_disabled", bus0.spawn_valid_out, 1);
        end
        s = n_starts;
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        check_eq("disabled_accept", bus0.spawn_valid_out, 0);
        repeat (5) cyc();
        check_eq("no_start_after_disable", n_starts, s);

        // async reset in the middle of a pending request
        enable = 1'b1;
        wait_start(6, n);
        check_eq("reenable_to_start", n, 2);
        pulse = 1'b1;
        repeat (100) cyc();
        pulse = 1'b0;
        check_eq("level_before_reset", lvl0, 1);
        exp_level = 1;
        push_expected();
        expired = 1'b1;
        cyc();
        expired = 1'b0;
        check_eq("valid_before_reset", bus0.spawn_valid_out, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", bus0.spawn_valid_out, 0);
        check_eq("midrst_value", val0, 0);
        check_eq("midrst_level", lvl0, 0);
        check_eq("midrst_value_jit", val1, 0);
        valid_q = 1'b0;
        sb_q.delete();
        exp_level = 0;
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        wait_start(6, n);
        check_eq("post_reset_to_start", n, 2);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
